// File: rtl/addr_exc_pkg.sv
// Shared encodings for the address-exception unit: access sizes, exception
// codes and FSM states.
package addr_exc_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } mem_size_e;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } exc_state_e;

endpackage

// File: rtl/addr_exc_if.sv
// Pipeline/CP0 side bundle of the address-exception unit. The pipeline and
// CP0 drive through master; the unit itself connects through slave.
interface addr_exc_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  import addr_exc_pkg::*;

  logic              stall;
  logic              user_mode;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic              mem_valid;
  mem_size_e         mem_size;
  logic              mem_is_store;
  logic [ADDR_W-1:0] mem_addr;
  logic              exc_ack;
  logic              mem_en_ok;
  logic              exc_valid;
  logic [4:0]        exc_code;
  logic [ADDR_W-1:0] exc_badvaddr;
  logic              exc_is_fetch;
  logic [CNT_W-1:0]  exc_count;

  modport master (
    output stall, user_mode, if_valid, if_pc, mem_valid, mem_size,
           mem_is_store, mem_addr, exc_ack,
    input  mem_en_ok, exc_valid, exc_code, exc_badvaddr, exc_is_fetch,
           exc_count
  );

  modport slave (
    input  stall, user_mode, if_valid, if_pc, mem_valid, mem_size,
           mem_is_store, mem_addr, exc_ack,
    output mem_en_ok, exc_valid, exc_code, exc_badvaddr, exc_is_fetch,
           exc_count
  );

endinterface

// File: rtl/addr_align_chk.sv
// Combinational alignment / privilege check for one access. Only the low
// three address bits and the kernel-space bit can influence the verdict.
module addr_align_chk
  import addr_exc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0] addr_lo,
  input  logic       addr_msb,
  input  mem_size_e  size,
  input  logic       is_store,
  input  logic       user_mode,
  output logic       fault,
  output logic [4:0] code
);

  logic misaligned;
  logic privileged;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_BYTE:  misaligned = 1'b0;
      SZ_HALF:  misaligned = addr_lo[0];
      SZ_WORD:  misaligned = (addr_lo[1:0] != 2'b00);
      // A 32-bit datapath has no doubleword access, so any dword request faults.
      SZ_DWORD: misaligned = (DATA_W == 64) ? (addr_lo != 3'b000) : 1'b1;
      default:  misaligned = 1'b0;
    endcase
  end

  assign privileged = user_mode & addr_msb;
  assign fault      = misaligned | privileged;
  assign code       = is_store ? EXC_ADES : EXC_ADEL;

endmodule

// File: rtl/addr_exc_unit.sv
// Address-exception unit: checks fetch and MEM accesses, gates the data SRAM
// enable, and holds one exception record until CP0 acknowledges it.
module addr_exc_unit
  import addr_exc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  addr_exc_if.slave  bus
);

  logic              if_fault_raw;
  logic              mem_fault_raw;
  logic              if_fault;
  logic              mem_fault;
  logic [4:0]        if_code;
  logic [4:0]        mem_code;
  logic              capture;
  logic              hold_valid;
  exc_state_e        state;
  exc_state_e        state_nx;

  logic [4:0]        rec_code;
  logic [ADDR_W-1:0] rec_badvaddr;
  logic              rec_is_fetch;
  logic [CNT_W-1:0]  rec_count;

  addr_align_chk #(.DATA_W(DATA_W)) u_if_chk (
    .addr_lo   (bus.if_pc[2:0]),
    .addr_msb  (bus.if_pc[ADDR_W-1]),
    .size      (SZ_WORD),
    .is_store  (1'b0),
    .user_mode (bus.user_mode),
    .fault     (if_fault_raw),
    .code      (if_code)
  );

  addr_align_chk #(.DATA_W(DATA_W)) u_mem_chk (
    .addr_lo   (bus.mem_addr[2:0]),
    .addr_msb  (bus.mem_addr[ADDR_W-1]),
    .size      (bus.mem_size),
    .is_store  (bus.mem_is_store),
    .user_mode (bus.user_mode),
    .fault     (mem_fault_raw),
    .code      (mem_code)
  );

  assign if_fault  = bus.if_valid  & if_fault_raw;
  assign mem_fault = bus.mem_valid & mem_fault_raw;

  // SRAM gating must not depend on stall or the held record.
  assign bus.mem_en_ok = bus.mem_valid & ~mem_fault_raw;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if ((mem_fault | if_fault) & ~bus.stall) state_nx = ST_HOLD;
      ST_HOLD: if (bus.exc_ack)                         state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    capture    = 1'b0;
    hold_valid = 1'b0;
    case (state)
      ST_IDLE: capture    = (mem_fault | if_fault) & ~bus.stall;
      ST_HOLD: hold_valid = 1'b1;
      default: ;
    endcase
  end

  // MEM side wins on a tie: it belongs to the older instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      rec_code     <= '0;
      rec_badvaddr <= '0;
      rec_is_fetch <= 1'b0;
    end else if (capture) begin
      if (mem_fault) begin
        rec_code     <= mem_code;
        rec_badvaddr <= bus.mem_addr;
        rec_is_fetch <= 1'b0;
      end else begin
        rec_code     <= if_code;
        rec_badvaddr <= bus.if_pc;
        rec_is_fetch <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                      rec_count <= '0;
    else if (capture && rec_count != {CNT_W{1'b1}}) rec_count <= rec_count + 1'b1;
  end

  assign bus.exc_valid    = hold_valid;
  assign bus.exc_code     = rec_code;
  assign bus.exc_badvaddr = rec_badvaddr;
  assign bus.exc_is_fetch = rec_is_fetch;
  assign bus.exc_count    = rec_count;

endmodule

// File: tb/tb_addr_exc_unit.sv
// Directed bench for addr_exc_unit: a vector table for the per-access fault
// rules plus hand-written sequences for priority, hold, stall, ack and reset.
module tb_addr_exc_unit;
  import addr_exc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addr_exc_if #(.ADDR_W(32), .CNT_W(16)) bus32 ();
  addr_exc_if #(.ADDR_W(32), .CNT_W(16)) bus64 ();
  addr_exc_if #(.ADDR_W(32), .CNT_W(2))  busc2 ();

  addr_exc_unit #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  addr_exc_unit #(.ADDR_W(32), .DATA_W(64), .CNT_W(16)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));
  addr_exc_unit #(.ADDR_W(32), .DATA_W(32), .CNT_W(2))  dutc2 (.clk(clk), .rst(rst), .bus(busc2.slave));

  typedef struct {
    logic        user;
    logic        valid;
    mem_size_e   size;
    logic        store;
    logic [31:0] addr;
    logic        en32;
    logic        en64;
    logic [4:0]  code;
  } vec_t;

  vec_t vecs[11];
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic um, input logic stl, input logic ifv, input logic [31:0] pc,
                       input logic mv, input mem_size_e sz, input logic st,
                       input logic [31:0] ad, input logic ack);
    bus32.user_mode = um;  bus64.user_mode = um;  busc2.user_mode = um;
    bus32.stall = stl;     bus64.stall = stl;     busc2.stall = stl;
    bus32.if_valid = ifv;  bus64.if_valid = ifv;  busc2.if_valid = ifv;
    bus32.if_pc = pc;      bus64.if_pc = pc;      busc2.if_pc = pc;
    bus32.mem_valid = mv;  bus64.mem_valid = mv;  busc2.mem_valid = mv;
    bus32.mem_size = sz;   bus64.mem_size = sz;   busc2.mem_size = sz;
    bus32.mem_is_store = st; bus64.mem_is_store = st; busc2.mem_is_store = st;
    bus32.mem_addr = ad;   bus64.mem_addr = ad;   busc2.mem_addr = ad;
    bus32.exc_ack = ack;   bus64.exc_ack = ack;   busc2.exc_ack = ack;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic ack_pulse();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, bus32.exc_valid, 0);
    check({tag, "_code"}, bus32.exc_code, 0);
    check({tag, "_bad"}, bus32.exc_badvaddr, 0);
    check({tag, "_fetch"}, bus32.exc_is_fetch, 0);
    check({tag, "_count"}, bus32.exc_count, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, SZ_WORD,  1'b0, 32'h0000_1002, 1'b0, 1'b0, EXC_ADEL};
    vecs[1]  = '{1'b0, 1'b1, SZ_WORD,  1'b0, 32'h0000_1000, 1'b1, 1'b1, EXC_ADEL};
    vecs[2]  = '{1'b0, 1'b1, SZ_HALF,  1'b1, 32'h0000_2001, 1'b0, 1'b0, EXC_ADES};
    vecs[3]  = '{1'b0, 1'b1, SZ_HALF,  1'b1, 32'h0000_2002, 1'b1, 1'b1, EXC_ADES};
    vecs[4]  = '{1'b1, 1'b1, SZ_BYTE,  1'b0, 32'h8000_0000, 1'b0, 1'b0, EXC_ADEL};
    vecs[5]  = '{1'b0, 1'b1, SZ_BYTE,  1'b0, 32'h8000_0000, 1'b1, 1'b1, EXC_ADEL};
    vecs[6]  = '{1'b0, 1'b1, SZ_DWORD, 1'b0, 32'h0000_0000, 1'b0, 1'b1, EXC_ADEL};
    vecs[7]  = '{1'b0, 1'b1, SZ_DWORD, 1'b0, 32'h0000_0004, 1'b0, 1'b0, EXC_ADEL};
    vecs[8]  = '{1'b0, 1'b1, SZ_WORD,  1'b1, 32'h0000_1003, 1'b0, 1'b0, EXC_ADES};
    vecs[9]  = '{1'b0, 1'b1, SZ_BYTE,  1'b1, 32'h0000_0003, 1'b1, 1'b1, EXC_ADES};
    vecs[10] = '{1'b0, 1'b0, SZ_WORD,  1'b0, 32'h0000_1003, 1'b0, 1'b0, EXC_ADEL};

    do_reset();
    check_zero("reset");

    // Table: same-cycle enable, then the captured record, then ack.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].user, 1'b0, 1'b0, 32'h0, vecs[i].valid, vecs[i].size,
            vecs[i].store, vecs[i].addr, 1'b0);
      #1;
      check($sformatf("v%0d_en32", i), bus32.mem_en_ok, vecs[i].en32);
      check($sformatf("v%0d_en64", i), bus64.mem_en_ok, vecs[i].en64);
      tick();
      idle();
      if (vecs[i].valid && !vecs[i].en32) begin
        exp_cnt++;
        check($sformatf("v%0d_valid", i), bus32.exc_valid, 1);
        check($sformatf("v%0d_code", i), bus32.exc_code, vecs[i].code);
        check($sformatf("v%0d_bad", i), bus32.exc_badvaddr, vecs[i].addr);
        check($sformatf("v%0d_fetch", i), bus32.exc_is_fetch, 0);
      end else begin
        check($sformatf("v%0d_novalid", i), bus32.exc_valid, 0);
      end
      check($sformatf("v%0d_count", i), bus32.exc_count, exp_cnt);
      ack_pulse();
      tick();
      idle();
      check($sformatf("v%0d_acked", i), bus32.exc_valid, 0);
    end

    // Simultaneous MEM and fetch faults: MEM record wins, one count.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h0040_0002, 1'b1, SZ_HALF, 1'b1, 32'h0000_2001, 1'b0);
    tick();
    idle();
    check("prio_valid", bus32.exc_valid, 1);
    check("prio_code", bus32.exc_code, EXC_ADES);
    check("prio_bad", bus32.exc_badvaddr, 32'h0000_2001);
    check("prio_fetch", bus32.exc_is_fetch, 0);
    check("prio_count", bus32.exc_count, 1);
    ack_pulse();
    tick();
    idle();

    // Fetch-only fault.
    drive(1'b0, 1'b0, 1'b1, 32'h0040_0001, 1'b0, SZ_BYTE, 1'b0, 32'h0, 1'b0);
    tick();
    idle();
    check("fetch_code", bus32.exc_code, EXC_ADEL);
    check("fetch_bad", bus32.exc_badvaddr, 32'h0040_0001);
    check("fetch_flag", bus32.exc_is_fetch, 1);
    check("fetch_count", bus32.exc_count, 2);

    // Record held: further faults ignored; ack clears valid but keeps fields.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h0000_0005, 1'b1, SZ_WORD, 1'b1, 32'h0000_2003, 1'b0);
      tick();
    end
    idle();
    check("hold_valid", bus32.exc_valid, 1);
    check("hold_bad", bus32.exc_badvaddr, 32'h0040_0001);
    check("hold_fetch", bus32.exc_is_fetch, 1);
    check("hold_count", bus32.exc_count, 2);
    ack_pulse();
    tick();
    idle();
    check("ack_valid", bus32.exc_valid, 0);
    check("ack_keep_bad", bus32.exc_badvaddr, 32'h0040_0001);

    // Stall blocks capture but not the SRAM gating.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, SZ_WORD, 1'b0, 32'h0000_1002, 1'b0);
    #1;
    check("stall_en", bus32.mem_en_ok, 0);
    tick();
    idle();
    check("stall_valid", bus32.exc_valid, 0);
    check("stall_count", bus32.exc_count, 2);

    // Ack together with a new fault in HOLD: back to IDLE, nothing captured.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, SZ_WORD, 1'b0, 32'h0000_1002, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, SZ_WORD, 1'b1, 32'h0000_2003, 1'b1);
    tick();
    idle();
    check("ackfault_valid", bus32.exc_valid, 0);
    check("ackfault_count", bus32.exc_count, 3);
    check("ackfault_code", bus32.exc_code, EXC_ADEL);
    tick();
    check("ackfault_valid2", bus32.exc_valid, 0);

    // Reset while holding a fetch record drops everything.
    drive(1'b0, 1'b0, 1'b1, 32'h0040_0003, 1'b0, SZ_BYTE, 1'b0, 32'h0, 1'b0);
    tick();
    idle();
    check("prerst_valid", bus32.exc_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("rsthold");

    // Counter saturation on the 2-bit instance.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, SZ_BYTE, 1'b0, 32'h8000_0000, 1'b0);
      tick();
      ack_pulse();
      tick();
      idle();
    end
    check("sat_c2", busc2.exc_count, 3);
    check("sat_c32", bus32.exc_count, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
